// File: rtl/pwm_led_bank.sv
// Multi-channel PWM/LED driver on the picorv32 native memory bus.
// Programmable prescaler, shadowed per-channel duty registers and a period-wrap interrupt.
module pwm_led_bank #(
    parameter int unsigned CHANNELS      = 8,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned PRESCALE_BITS = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_rdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq_wrap
);

    localparam logic [4:0]          REG_CTRL     = 5'd0;
    localparam logic [4:0]          REG_PRESCALE = 5'd1;
    localparam logic [4:0]          REG_COUNT    = 5'd2;
    localparam logic [4:0]          REG_DUTY0    = 5'd4;
    localparam logic [PWM_BITS-1:0] COUNT_MAX    = '1;

    logic                     run;
    logic                     invert;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PRESCALE_BITS-1:0] prescale_nxt;
    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [PWM_BITS-1:0]      count;
    logic [PWM_BITS-1:0]      shadow     [CHANNELS];
    logic [PWM_BITS-1:0]      shadow_nxt [CHANNELS];
    logic [PWM_BITS-1:0]      active     [CHANNELS];

    logic        accept;
    logic        wr_en;
    logic        ctrl_we;
    logic [4:0]  word;
    logic [31:0] wmask;
    logic        tick;
    logic        wrap_tick;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign accept    = mem_valid & enable & ~mem_ready;
    assign wr_en     = accept & (|mem_wstrb);
    assign word      = mem_addr[6:2];
    assign ctrl_we   = wr_en && (word == REG_CTRL) && mem_wstrb[0];
    assign wmask     = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign tick      = run && (pre_cnt == prescale);
    assign wrap_tick = tick && (count == COUNT_MAX);

    assign unused_bits = ^{mem_addr[31:7], mem_addr[1:0], mem_wdata, wmask};

    always_comb begin
        prescale_nxt = prescale;
        if (wr_en && (word == REG_PRESCALE)) begin
            prescale_nxt = (prescale & ~wmask[PRESCALE_BITS-1:0])
                         | (mem_wdata[PRESCALE_BITS-1:0] & wmask[PRESCALE_BITS-1:0]);
        end
    end

    // Shadow next-state is shared with the active-duty load so a write landing on a wrap tick takes effect.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow_nxt[i] = shadow[i];
            if (wr_en && (word == REG_DUTY0 + 5'(i))) begin
                shadow_nxt[i] = (shadow[i] & ~wmask[PWM_BITS-1:0])
                              | (mem_wdata[PWM_BITS-1:0] & wmask[PWM_BITS-1:0]);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (word)
            REG_CTRL:     rd_val = {30'd0, invert, run};
            REG_PRESCALE: rd_val = 32'(prescale);
            REG_COUNT:    rd_val = 32'(count);
            default:      ;
        endcase
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (word == REG_DUTY0 + 5'(i)) rd_val = 32'(shadow[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            run       <= 1'b0;
            invert    <= 1'b0;
            prescale  <= '0;
            pre_cnt   <= '0;
            count     <= '0;
            irq_wrap  <= 1'b0;
            pwm_out   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            mem_ready <= accept;
            mem_rdata <= accept ? rd_val : '0;
            if (ctrl_we) {invert, run} <= mem_wdata[1:0];
            prescale <= prescale_nxt;

            if (!run) begin
                pre_cnt <= '0;
                count   <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                count   <= count + PWM_BITS'(1);
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
            end

            irq_wrap <= wrap_tick;

            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (!run || wrap_tick) active[i] <= shadow_nxt[i];
                pwm_out[i] <= run ? ((count < active[i]) ^ invert) : invert;
            end
        end
    end

endmodule

// File: doc/pwm_led_bank.md
Name: pwm_led_bank

Overview:
- Memory-mapped, multi-channel PWM/LED driver.
- Slave on the picorv32 native memory bus; selected by one address_decoder enable line.
- Replaces the fixed-tap clock divider plus hard-wired LED assignment with:
  - a programmable prescaler;
  - per-channel duty registers;
  - glitch-free duty updates at period boundaries;
  - a period-wrap interrupt pulse.

Parameters:
- CHANNELS, 8, number of PWM outputs (1..16).
- PWM_BITS, 8, PWM counter/duty width (2..16); period = 2^PWM_BITS ticks.
- PRESCALE_BITS, 16, prescaler register/counter width (1..32).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  chip select from address_decoder.
- mem_valid  in  1  bus request valid.
- mem_ready  out  1  bus acknowledge, one-cycle pulse.
- mem_addr  in  32  byte address; only [6:2] decoded.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 = read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- pwm_out  out  CHANNELS  PWM outputs, bit i = channel i.
- irq_wrap  out  1  one-cycle pulse at each PWM period wrap.

Behaviour:
- Reset (resetn low, async):
  - mem_ready=0, mem_rdata=0, pwm_out=0, irq_wrap=0.
  - CTRL=0, PRESCALE=0, all shadow/active duty=0, prescaler and PWM counters=0.
- Register map (word offset = mem_addr[6:2]):
  - 0x00 CTRL: [0] RUN, [1] INVERT; other bits read 0.
  - 0x04 PRESCALE: PRESCALE_BITS wide, zero-extended on read.
  - 0x08 COUNT: read-only current PWM counter; writes ignored.
  - 0x10+4*i DUTY[i] for i<CHANNELS: write shadow, read shadow.
  - Any other offset: reads return 0, writes ignored, still acknowledged.
- Bus handshake:
  - A request is accepted in a cycle where mem_valid & enable & !mem_ready.
  - mem_ready=1 the following cycle, for exactly one cycle; mem_rdata is registered with it.
  - No accept while mem_ready=1, so a held mem_valid gets one ack per two cycles.
  - Write:
    - Each byte lane with mem_wstrb[k]=1 updates bits [8k+7:8k] of the target register; bits beyond register width are dropped.
    - The write takes effect in the accept cycle, so the register holds the new value when mem_ready=1.
  - Read:
    - mem_rdata is captured in the accept cycle and returns the pre-write value.
    - mem_rdata returns to 0 when mem_ready=0.
- Prescaler and counter (RUN=1):
  - The prescaler counts 0..PRESCALE; when it equals PRESCALE it emits a tick and reloads 0.
  - PRESCALE=0 gives a tick every cycle.
  - The PWM counter increments on each tick, wrapping from 2^PWM_BITS-1 to 0.
  - PRESCALE written below the current prescaler count: tick fires on the next compare-equal after natural wrap at 2^PRESCALE_BITS-1.
- Duty update:
  - The active duty copies from shadow on a wrap tick (the tick where the counter goes max->0), and continuously while RUN=0.
  - A shadow write in the same cycle as a wrap tick is loaded into active.
- Output:
  - pwm_out[i] = ((count < active_duty[i]) ^ INVERT), registered, so it lags count by 1 cycle.
  - Duty 0 is always low (non-inverted).
  - Duty 2^PWM_BITS-1 is high for all but one count.
- irq_wrap: registered pulse 1 cycle after each wrap tick; never asserted while RUN=0.
- RUN=0:
  - Prescaler and counter are held at 0.
  - pwm_out = {CHANNELS{INVERT}}.
- RUN 0->1: counting starts next cycle from 0, with active duty = shadow.
- Reset mid-transaction: mem_ready drops immediately and the pending request is discarded.

Test Plan:
1. Reset, then read 0x00, 0x04, 0x08, 0x10 -> all return 0; pwm_out=0; mem_ready pulses exactly 1 cycle, 1 cycle after mem_valid.
2. Write PRESCALE=3, DUTY[0]=64, DUTY[1]=0, DUTY[2]=255, CTRL=1 -> ch0 high 64 of 256 ticks (256 of 1024 clk); ch1 always 0; ch2 low exactly 1 tick per period; irq_wrap pulses every 1024 clk.
3. Running with DUTY[0]=64, write DUTY[0]=200 mid-period -> current period keeps 64-tick high time; next period after wrap shows 200; reading 0x10 returns 200 immediately.
4. Write 0x00 with wstrb=4'b0001, wdata=32'h0000_0003 (RUN|INVERT) and DUTY[3]=0 -> pwm_out[3]=1 constantly; clear RUN -> all pwm_out=1, COUNT reads 0, no irq_wrap.
5. Byte-lane write to PRESCALE: wdata=32'hAABB_CCDD, wstrb=4'b0010 -> read 0x04 returns 32'h0000_CC00 (PRESCALE_BITS=16); write 0x08 and 0x7C -> ignored, reads 0x08=count, 0x7C=0, both acked.
6. Hold mem_valid&enable high for 6 cycles -> mem_ready pulses on cycles 2, 4, 6 only; assert resetn=0 on a cycle with mem_ready=1 -> mem_ready drops at once, all registers zero.
